mem_dp_lat: RTL and testbench

- Parametrised dual-port memory for the mp3 bench and integration, generalising the fixed 16-bit dual-port memory.
- Adds configurable data width, depth and per-port response latency, plus byte-masked writes on both ports.
- Defines collision behaviour when both ports access the same word in the same cycle.
- Sits between the CPU's instruction port (A) and data port (B) and a behavioural array.
- Uses the same read/write/resp request-hold handshake as the existing memory.

---
 rtl/mem_dp_pkg.sv | 21 ++
 rtl/mem_dp_port_ctrl.sv | 62 ++++++
 rtl/mem_dp_lat.sv | 111 +++++++++++
 tb/tb_mem_dp_lat.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dp_pkg.sv
// Shared types and helpers for the parametrised dual-port latency memory.
// Covers port controller states, read-during-write modes and counter sizing.
package mem_dp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } port_state_t;

    typedef enum logic {
        RDW_OLD,
        RDW_NEW
    } rdw_mode_t;

    // The counter only ever holds values up to LAT-1, so clog2(LAT) bits suffice.
    function automatic int cnt_w(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_dp_port_ctrl.sv
// Per-port request FSM: accepts in IDLE and pulses resp exactly LAT cycles later.
// No backpressure; the requester holds its strobes, which are ignored outside IDLE.
module mem_dp_port_ctrl
    import mem_dp_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic accept,
    output logic resp
);

    localparam int CW = cnt_w(LAT);

    port_state_t   state;
    logic [CW-1:0] cnt;

    // Held strobes are still high on the edge that ends RESP; only IDLE may accept.
    assign accept = (state == IDLE) && req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            resp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (LAT == 1) begin
                            state <= RESP;
                            resp  <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                        resp  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    resp  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    resp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_dp_lat.sv
// Dual-port byte-masked memory with per-port response latency LAT_A / LAT_B.
// Requests are held until resp; same-word collisions resolve with port B winning.
module mem_dp_lat
    import mem_dp_pkg::*;
#(
    parameter int        DATA_W   = 16,
    parameter int        ADDR_W   = 16,
    parameter int        LAT_A    = 1,
    parameter int        LAT_B    = 1,
    parameter rdw_mode_t RDW_MODE = RDW_OLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_a,
    input  logic                write_a,
    input  logic [ADDR_W-1:0]   address_a,
    input  logic [DATA_W/8-1:0] wmask_a,
    input  logic [DATA_W-1:0]   wdata_a,
    output logic                resp_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic                read_b,
    input  logic                write_b,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W/8-1:0] wmask_b,
    input  logic [DATA_W-1:0]   wdata_b,
    output logic                resp_b,
    output logic [DATA_W-1:0]   rdata_b
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFS;
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept_a, accept_b;
    logic             wr_a, wr_b, rd_a, rd_b, same;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [DATA_W-1:0] cur_a, cur_b, final_a, final_b;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [BYTES-1:0]  m);
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < BYTES; i++) begin
            if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    mem_dp_port_ctrl #(.LAT(LAT_A)) u_ctrl_a (
        .clk    (clk),
        .rst    (rst),
        .req    (read_a | write_a),
        .accept (accept_a),
        .resp   (resp_a)
    );

    mem_dp_port_ctrl #(.LAT(LAT_B)) u_ctrl_b (
        .clk    (clk),
        .rst    (rst),
        .req    (read_b | write_b),
        .accept (accept_b),
        .resp   (resp_b)
    );

    assign idx_a = address_a[ADDR_W-1:OFS];
    assign idx_b = address_b[ADDR_W-1:OFS];
    assign cur_a = mem[idx_a];
    assign cur_b = mem[idx_b];
    assign wr_a  = accept_a & write_a;
    assign wr_b  = accept_b & write_b;
    assign rd_a  = accept_a & read_a;
    assign rd_b  = accept_b & read_b;
    assign same  = (idx_a == idx_b);

    // A's bytes are applied first so overlapping B bytes override them; on a
    // shared word both ports compute the identical merged value.
    assign final_a = merge(merge(cur_a, wdata_a, wr_a ? wmask_a : '0),
                           wdata_b, (same && wr_b) ? wmask_b : '0);
    assign final_b = merge(merge(cur_b, wdata_a, (same && wr_a) ? wmask_a : '0),
                           wdata_b, wr_b ? wmask_b : '0);

    always_ff @(posedge clk) begin
        if (wr_a) mem[idx_a] <= final_a;
        if (wr_b) mem[idx_b] <= final_b;
    end

    // A port writing its own word always captures the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (rd_a)
                rdata_a <= (RDW_MODE == RDW_NEW && !write_a && same && wr_b) ? final_a : cur_a;
            if (rd_b)
                rdata_b <= (RDW_MODE == RDW_NEW && !write_b && same && wr_a) ? final_b : cur_b;
        end
    end

    generate
        if (OFS > 0) begin : g_ofs
            logic unused_ofs;
            assign unused_ofs = ^{address_a[OFS-1:0], address_b[OFS-1:0]};
        end
    endgenerate

endmodule

// File: tb/tb_mem_dp_lat.sv
// Scoreboard bench: dut0 is 16-bit, LAT 1/1, RDW_OLD; dut1 is 32-bit, LAT 3/4, RDW_NEW.
// Logical ports 0,1 are dut0 A,B and ports 2,3 are dut1 A,B.
module tb_mem_dp_lat;
    import mem_dp_pkg::*;

    typedef struct packed {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        rdv [4];
    logic        wrv [4];
    logic [15:0] adv [4];
    logic [3:0]  mkv [4];
    logic [31:0] wdv [4];
    logic        rsp [4];
    logic [31:0] rdat [4];
    logic [15:0] rd16_a, rd16_b;
    logic [31:0] rd32_a, rd32_b;

    exp_t q0[$], q1[$], q2[$], q3[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_dp_lat #(.DATA_W(16), .ADDR_W(16), .LAT_A(1), .LAT_B(1), .RDW_MODE(RDW_OLD)) dut0 (
        .clk(clk), .rst(rst0),
        .read_a(rdv[0]), .write_a(wrv[0]), .address_a(adv[0]), .wmask_a(mkv[0][1:0]),
        .wdata_a(wdv[0][15:0]), .resp_a(rsp[0]), .rdata_a(rd16_a),
        .read_b(rdv[1]), .write_b(wrv[1]), .address_b(adv[1]), .wmask_b(mkv[1][1:0]),
        .wdata_b(wdv[1][15:0]), .resp_b(rsp[1]), .rdata_b(rd16_b)
    );

    mem_dp_lat #(.DATA_W(32), .ADDR_W(16), .LAT_A(3), .LAT_B(4), .RDW_MODE(RDW_NEW)) dut1 (
        .clk(clk), .rst(rst1),
        .read_a(rdv[2]), .write_a(wrv[2]), .address_a(adv[2]), .wmask_a(mkv[2]),
        .wdata_a(wdv[2]), .resp_a(rsp[2]), .rdata_a(rd32_a),
        .read_b(rdv[3]), .write_b(wrv[3]), .address_b(adv[3]), .wmask_b(mkv[3]),
        .wdata_b(wdv[3]), .resp_b(rsp[3]), .rdata_b(rd32_b)
    );

    assign rdat[0] = {16'h0, rd16_a};
    assign rdat[1] = {16'h0, rd16_b};
    assign rdat[2] = rd32_a;
    assign rdat[3] = rd32_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void push(input int p, input exp_t e);
        case (p)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int p);
        case (p)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic exp_t pop(input int p);
        case (p)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Monitor: every resp pulse consumes one scoreboard entry for its port.
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (rsp[p] === 1'b1) begin
                if (qsize(p) == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp port=%0d actual=1 required=0", p);
                end else begin
                    exp_t e;
                    e = pop(p);
                    if (e.chk) check($sformatf("rdata_p%0d", p), rdat[p], e.val);
                end
            end
        end
    end

    task automatic op(input int p, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [3:0] m, input logic [31:0] d, input bit chk,
                      input logic [31:0] ev, input int lat);
        int n;
        push(p, '{chk: chk, val: ev});
        @(negedge clk);
        rdv[p] = rd; wrv[p] = wr; adv[p] = addr; mkv[p] = m; wdv[p] = d;
        n = 0;
        @(negedge clk);
        while (rsp[p] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("resp_latency_p%0d", p), 32'(n), 32'(lat - 1));
        @(posedge clk);
        #1;
        rdv[p] = 1'b0; wrv[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int p = 0; p < 4; p++) begin
            rdv[p] = 1'b0; wrv[p] = 1'b0; adv[p] = '0; mkv[p] = '0; wdv[p] = '0;
        end
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("reset_resp_p%0d", p), 32'(rsp[p]), 32'h0);
            check($sformatf("reset_rdata_p%0d", p), rdat[p], 32'h0);
        end

        // dut0: basic write on B, read on A
        op(1, 0, 1, 16'h0010, 4'h3, 32'h1234, 0, 32'h0, 1);
        op(0, 1, 0, 16'h0010, 4'h0, 32'h0, 1, 32'h1234, 1);

        // byte mask and ignored low address bit
        op(1, 0, 1, 16'h0030, 4'h3, 32'hAABB, 0, 32'h0, 1);
        op(1, 0, 1, 16'h0030, 4'h1, 32'h1122, 0, 32'h0, 1);
        op(0, 1, 0, 16'h0030, 4'h0, 32'h0, 1, 32'hAA22, 1);
        op(0, 1, 0, 16'h0031, 4'h0, 32'h0, 1, 32'hAA22, 1);

        // write/write collision: B wins
        op(1, 0, 1, 16'h0020, 4'h3, 32'h0000, 0, 32'h0, 1);
        fork
            op(0, 0, 1, 16'h0020, 4'h3, 32'h5555, 0, 32'h0, 1);
            op(1, 0, 1, 16'h0020, 4'h3, 32'h6666, 0, 32'h0, 1);
        join
        op(0, 1, 0, 16'h0020, 4'h0, 32'h0, 1, 32'h6666, 1);

        // read/write collision under RDW_OLD
        fork
            op(0, 1, 0, 16'h0020, 4'h0, 32'h0, 1, 32'h6666, 1);
            op(1, 0, 1, 16'h0020, 4'h3, 32'h7777, 0, 32'h0, 1);
        join
        op(1, 1, 0, 16'h0020, 4'h0, 32'h0, 1, 32'h7777, 1);

        // disjoint-byte collision merges
        fork
            op(0, 0, 1, 16'h0040, 4'h2, 32'hAB00, 0, 32'h0, 1);
            op(1, 0, 1, 16'h0040, 4'h1, 32'h00CD, 0, 32'h0, 1);
        join
        op(0, 1, 0, 16'h0040, 4'h0, 32'h0, 1, 32'hABCD, 1);

        // read+write together returns pre-write data
        op(0, 0, 1, 16'h0050, 4'h3, 32'h0001, 0, 32'h0, 1);
        op(0, 1, 1, 16'h0050, 4'h3, 32'hBEEF, 1, 32'h0001, 1);
        op(0, 1, 0, 16'h0050, 4'h0, 32'h0, 1, 32'hBEEF, 1);

        // read/read collision
        fork
            op(0, 1, 0, 16'h0050, 4'h0, 32'h0, 1, 32'hBEEF, 1);
            op(1, 1, 0, 16'h0050, 4'h0, 32'h0, 1, 32'hBEEF, 1);
        join

        // dut1: LAT_B=4, held read not re-accepted
        op(3, 0, 1, 16'h0100, 4'hF, 32'hDEADBEEF, 0, 32'h0, 4);
        op(3, 1, 0, 16'h0100, 4'h0, 32'h0, 1, 32'hDEADBEEF, 4);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp[3] === 1'b1) cnt++;
        end
        check("no_reaccept_p3", 32'(cnt), 32'h0);

        // read/write collision under RDW_NEW with byte merge
        op(3, 0, 1, 16'h0200, 4'hF, 32'h11111111, 0, 32'h0, 4);
        fork
            op(2, 1, 0, 16'h0200, 4'h0, 32'h0, 1, 32'h11112222, 3);
            op(3, 0, 1, 16'h0200, 4'h3, 32'h00002222, 0, 32'h0, 4);
        join
        op(2, 1, 0, 16'h0200, 4'h0, 32'h0, 1, 32'h11112222, 3);

        // reset during WAIT abandons the read; array contents survive
        op(2, 0, 1, 16'h0300, 4'hF, 32'hCAFEF00D, 0, 32'h0, 3);
        op(2, 1, 0, 16'h0300, 4'h0, 32'h0, 1, 32'hCAFEF00D, 3);
        @(negedge clk);
        rdv[2] = 1'b1; adv[2] = 16'h0100;
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0; rdv[2] = 1'b0;
        check("rst_rdata_p2", rdat[2], 32'h0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp[2] === 1'b1) cnt++;
        end
        check("rst_no_resp_p2", 32'(cnt), 32'h0);
        op(2, 1, 0, 16'h0300, 4'h0, 32'h0, 1, 32'hCAFEF00D, 3);

        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("scoreboard_empty_p%0d", p), 32'(qsize(p)), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
